// File: rtl/pacman_life_controller_pkg.sv
// Shared encodings and widths for the pacman round/lives controller.
package pacman_life_controller_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LIVES_W = 3;
    localparam int unsigned ANIM_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_RESPAWN   = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    // Lives never go below zero, even if a death is reported with none left.
    function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] lives);
        return (lives == '0) ? lives : lives - LIVES_W'(1);
    endfunction

endpackage

// File: rtl/pacman_life_controller_frame_timer.sv
// Frame counter: cleared by clr, advanced by en, hit_c flags the target count.
module pacman_life_controller_frame_timer #(
    parameter int unsigned W      = 8,
    parameter int unsigned TARGET = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         hit_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign hit_c = (count == W'(TARGET));

endmodule

// File: rtl/pacman_life_controller.sv
// Round/lives FSM: death animation, respawn pulse, game over.
// Optional collision immunity after respawn: define PACMAN_LIFE_INVULN_EN.
module pacman_life_controller
    import pacman_life_controller_pkg::*;
#(
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned DEATH_FRAMES  = 60
`ifdef PACMAN_LIFE_INVULN_EN
    ,
    parameter int unsigned INVULN_FRAMES = 90
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               pacman_is_dead,
    input  logic               start_btn,
    output logic [LIVES_W-1:0] lives_left,
    output logic [STATE_W-1:0] game_state,
    output logic               freeze_motion,
    output logic               respawn_pulse,
    output logic [ANIM_W-1:0]  death_anim_idx,
`ifdef PACMAN_LIFE_INVULN_EN
    output logic               invulnerable,
`endif
    output logic               game_over
);

    state_t              state;
    logic [ANIM_W-1:0]   timer;
    logic                timer_hit_c;
    logic                death_c;

    assign game_state = state;

    // Timer sits at zero outside DYING so it always enters the animation cleared.
    pacman_life_controller_frame_timer #(
        .W      (ANIM_W),
        .TARGET (DEATH_FRAMES - 1)
    ) u_death_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != ST_DYING),
        .en    (frame_tick),
        .count (timer),
        .hit_c (timer_hit_c)
    );

`ifdef PACMAN_LIFE_INVULN_EN
    localparam int unsigned INV_W = (INVULN_FRAMES > 255) ? 16 : 8;

    logic [INV_W-1:0] inv_count;
    logic             inv_hit_c;

    pacman_life_controller_frame_timer #(
        .W      (INV_W),
        .TARGET (INVULN_FRAMES - 1)
    ) u_invuln_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == ST_RESPAWN),
        .en    (frame_tick && invulnerable),
        .count (inv_count),
        .hit_c (inv_hit_c)
    );

    // Window opens on the RESPAWN->PLAY edge and closes after the last tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            invulnerable <= 1'b0;
        end else if (state == ST_RESPAWN) begin
            invulnerable <= 1'b1;
        end else if (frame_tick && inv_hit_c) begin
            invulnerable <= 1'b0;
        end
    end

    assign death_c = pacman_is_dead && !invulnerable;
`else
    assign death_c = pacman_is_dead;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            lives_left     <= '0;
            freeze_motion  <= 1'b1;
            respawn_pulse  <= 1'b0;
            death_anim_idx <= '0;
            game_over      <= 1'b0;
        end else begin
            respawn_pulse <= 1'b0;
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start_btn) begin
                        state         <= ST_RESPAWN;
                        lives_left    <= LIVES_W'(START_LIVES);
                        respawn_pulse <= 1'b1;
                        game_over     <= 1'b0;
                    end
                end
                ST_RESPAWN: begin
                    state         <= ST_PLAY;
                    freeze_motion <= 1'b0;
                end
                ST_PLAY: begin
                    // A death takes priority over a frame tick in the same cycle.
                    if (death_c) begin
                        state          <= ST_DYING;
                        freeze_motion  <= 1'b1;
                        lives_left     <= lives_dec(lives_left);
                        death_anim_idx <= '0;
                    end
                end
                ST_DYING: begin
                    if (frame_tick) begin
                        if (timer_hit_c) begin
                            death_anim_idx <= '0;
                            if (lives_left == '0) begin
                                state     <= ST_GAME_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state         <= ST_RESPAWN;
                                respawn_pulse <= 1'b1;
                            end
                        end else begin
                            death_anim_idx <= timer + ANIM_W'(1);
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    freeze_motion <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_life_controller.sv
// Randomized scoreboard bench for pacman_life_controller.
module tb_pacman_life_controller;

    localparam int START_LIVES   = 3;
    localparam int DEATH_FRAMES  = 60;
    localparam int INVULN_FRAMES = 90;

    localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_RESPAWN = 3, M_OVER = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       pacman_is_dead = 1'b0;
    logic       start_btn = 1'b0;
    logic [2:0] lives_left;
    logic [2:0] game_state;
    logic       freeze_motion;
    logic       respawn_pulse;
    logic [7:0] death_anim_idx;
    logic       game_over;
`ifdef PACMAN_LIFE_INVULN_EN
    logic       invulnerable;
`endif

    always #5 clk = ~clk;

    pacman_life_controller dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .pacman_is_dead (pacman_is_dead),
        .start_btn      (start_btn),
        .lives_left     (lives_left),
        .game_state     (game_state),
        .freeze_motion  (freeze_motion),
        .respawn_pulse  (respawn_pulse),
        .death_anim_idx (death_anim_idx),
`ifdef PACMAN_LIFE_INVULN_EN
        .invulnerable   (invulnerable),
`endif
        .game_over      (game_over)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] lives;
        logic       frz;
        logic       rsp;
        logic [7:0] idx;
        logic       ovr;
        logic       inv;
    } obs_t;

    obs_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: game mode, lives, animation frame, immunity frames left.
    int m_mode = M_IDLE, m_lives = 0, m_anim = 0, m_inv = 0;

    function automatic obs_t model_out();
        obs_t e;
        e.st    = 3'(m_mode);
        e.lives = 3'(m_lives);
        e.frz   = (m_mode != M_PLAY);
        e.rsp   = (m_mode == M_RESPAWN);
        e.idx   = (m_mode == M_DYING) ? 8'(m_anim) : 8'd0;
        e.ovr   = (m_mode == M_OVER);
        e.inv   = (m_inv != 0);
        return e;
    endfunction

    function automatic obs_t dut_out();
        obs_t g;
        g.st    = game_state;
        g.lives = lives_left;
        g.frz   = freeze_motion;
        g.rsp   = respawn_pulse;
        g.idx   = death_anim_idx;
        g.ovr   = game_over;
`ifdef PACMAN_LIFE_INVULN_EN
        g.inv   = invulnerable;
`else
        g.inv   = 1'b0;
`endif
        return g;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit t, input bit d);
        if (r) begin
            m_mode = M_IDLE; m_lives = 0; m_anim = 0; m_inv = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_OVER: if (s) begin m_mode = M_RESPAWN; m_lives = START_LIVES; end
                M_RESPAWN: begin
                    m_mode = M_PLAY;
`ifdef PACMAN_LIFE_INVULN_EN
                    m_inv = INVULN_FRAMES;
`endif
                end
                M_PLAY: begin
                    if (m_inv > 0) begin
                        if (t) m_inv--;
                    end else if (d) begin
                        m_mode = M_DYING;
                        m_anim = 0;
                        if (m_lives > 0) m_lives--;
                    end
                end
                M_DYING: begin
                    if (t) begin
                        if (m_anim == DEATH_FRAMES - 1) begin
                            m_anim = 0;
                            m_mode = (m_lives == 0) ? M_OVER : M_RESPAWN;
                        end else begin
                            m_anim++;
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit s, input bit t, input bit d);
        @(negedge clk);
        rst = r; start_btn = s; frame_tick = t; pacman_is_dead = d;
        model_step(r, s, t, d);
        q.push_back(model_out());
    endtask

    // Monitor: every registered output update is checked against the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                obs_t e;
                obs_t g;
                e = q.pop_front();
                g = dut_out();
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL outputs t=%0t got st=%0d lives=%0d frz=%0b rsp=%0b idx=%0d ovr=%0b inv=%0b exp st=%0d lives=%0d frz=%0b rsp=%0b idx=%0d ovr=%0b inv=%0b",
                             $time, g.st, g.lives, g.frz, g.rsp, g.idx, g.ovr, g.inv,
                             e.st, e.lives, e.frz, e.rsp, e.idx, e.ovr, e.inv);
                end
            end
        end
    end

    initial begin
        int dead_left = 0;
        bit d;

        repeat (3) step(1, 0, 0, 0);

        // Start, play, then death coinciding with a frame tick.
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 300 && m_mode == M_DYING; i++) step(0, 0, 32'($urandom % 2) == 1, 0);

        // Dead held high: one life per death, repeated deaths down to game over.
        for (int i = 0; i < 1200 && m_mode != M_OVER; i++) step(0, 0, 32'($urandom % 2) == 1, 1);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Randomized play with held collision bursts and rare resets.
        for (int i = 0; i < 4000; i++) begin
            if (dead_left > 0) begin
                d = 1'b1;
                dead_left--;
            end else begin
                d = 1'b0;
                if ($urandom % 40 == 0) dead_left = int'($urandom_range(1, 80));
            end
            step(($urandom % 1500) == 0, ($urandom % 25) == 0, ($urandom % 2) == 1, d);
        end

        // Asynchronous reset in the middle of the death animation.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 300 && m_mode != M_PLAY; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 400 && !(m_mode == M_DYING && m_anim == 30); i++)
            step(0, 0, 1, m_mode == M_PLAY);
        @(negedge clk);
        tests++;
        if (death_anim_idx !== 8'd30 || game_state !== 3'd2) begin
            fails++;
            $display("FAIL pre_reset_idx got idx=%0d st=%0d exp idx=30 st=2", death_anim_idx, game_state);
        end
        rst = 1'b1; start_btn = 1'b0; frame_tick = 1'b0; pacman_is_dead = 1'b0;
        #1;
        tests++;
        if ({game_state, lives_left, freeze_motion, respawn_pulse, death_anim_idx, game_over} !==
            {3'd0, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL async_reset got st=%0d lives=%0d frz=%0b rsp=%0b idx=%0d ovr=%0b exp st=0 lives=0 frz=1 rsp=0 idx=0 ovr=0",
                     game_state, lives_left, freeze_motion, respawn_pulse, death_anim_idx, game_over);
        end
        model_step(1, 0, 0, 0);
        q.push_back(model_out());
        step(1, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            step(0, ($urandom % 20) == 0, ($urandom % 2) == 1, ($urandom % 10) == 0);

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
